// File: rtl/lsu_pkg.sv
// Shared types and constants for the MEM-stage load/store unit:
// access width codes, FSM states and byte-enable patterns.
package lsu_pkg;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [3:0] BE_B = 4'b0001;
  localparam logic [3:0] BE_H = 4'b0011;
  localparam logic [3:0] BE_W = 4'b1111;

  // FP and atomic accesses are always word; unknown funct3 codes fall back to word.
  function automatic size_e decode_size(input logic force_word, input logic [2:0] f3);
    size_e sz;
    sz = SZ_W;
    if (!force_word) begin
      case (f3)
        F3_B, F3_BU: sz = SZ_B;
        F3_H, F3_HU: sz = SZ_H;
        default:     sz = SZ_W;
      endcase
    end
    return sz;
  endfunction

endpackage

// File: rtl/memory_stage_lsu_if.sv
// Data-memory bus: req/gnt address phase, rvalid data/ack phase.
interface memory_stage_lsu_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_be;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: store byte-enable/replication and
// load byte/half extraction with sign or zero extension.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  size_e             st_size,
  input  logic [1:0]        st_lo,
  input  logic [DATA_W-1:0] st_data,
  output logic [3:0]        st_be,
  output logic [DATA_W-1:0] st_wdata,
  input  size_e             ld_size,
  input  logic              ld_unsigned,
  input  logic [1:0]        ld_lo,
  input  logic [DATA_W-1:0] ld_raw,
  output logic [DATA_W-1:0] ld_data
);

  logic [7:0]  w_lane [4];
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign w_lane[gi] = ld_raw[8*gi +: 8];
  end

  assign w_byte = w_lane[ld_lo];
  assign w_half = ld_lo[1] ? {w_lane[3], w_lane[2]} : {w_lane[1], w_lane[0]};

  always_comb begin
    st_be    = BE_W;
    st_wdata = st_data;
    case (st_size)
      SZ_B: begin
        st_be    = BE_B << st_lo;
        st_wdata = {4{st_data[7:0]}};
      end
      SZ_H: begin
        st_be    = BE_H << st_lo;
        st_wdata = {2{st_data[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_data = ld_raw;
    case (ld_size)
      SZ_B: ld_data = {{(DATA_W-8){w_byte[7] & ~ld_unsigned}}, w_byte};
      SZ_H: ld_data = {{(DATA_W-16){w_half[15] & ~ld_unsigned}}, w_half};
      default: ;
    endcase
  end

endmodule

// File: rtl/memory_stage_lsu.sv
// MEM-stage load/store unit: access FSM, request registers and LR/SC
// reservation in front of a variable-latency req/gnt/rvalid data memory.
module memory_stage_lsu
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter bit RSV_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MemReadM,
  input  logic              MemWriteM,
  input  logic              isFPUM,
  input  logic              isLRM,
  input  logic              isSCM,
  input  logic [2:0]        funct3M,
  input  logic [ADDR_W-1:0] ALU_ResultM,
  input  logic [DATA_W-1:0] WriteDataM,
  output logic [DATA_W-1:0] ReadDataM,
  output logic              StallM,
  output logic              MisalignM,
  memory_stage_lsu_if.master bus
);

  if (DATA_W != 32) begin : g_bad_width
    $error("memory_stage_lsu supports DATA_W=32 only");
  end

  state_e            r_state, w_state_next;
  size_e             w_size, r_size;
  logic              w_access, w_we, w_misalign, w_sc_ok;
  logic [3:0]        w_st_be;
  logic [DATA_W-1:0] w_st_wdata, w_ld_data;
  logic              r_unsigned, r_we, r_lr, r_sc, r_misalign;
  logic [1:0]        r_lo;
  logic [ADDR_W-1:0] r_addr;
  logic [3:0]        r_be;
  logic [DATA_W-1:0] r_wdata, r_rdata;
  logic [ADDR_W-3:0] r_rsv_addr;
  logic              r_rsv_valid;

  assign w_access   = MemReadM | MemWriteM | isLRM | isSCM;
  assign w_we       = MemWriteM | isSCM;
  assign w_size     = decode_size(isFPUM | isLRM | isSCM, funct3M);
  assign w_misalign = ((w_size == SZ_H) && ALU_ResultM[0]) ||
                      ((w_size == SZ_W) && (ALU_ResultM[1:0] != 2'b00));
  assign w_sc_ok    = RSV_EN && r_rsv_valid && (r_rsv_addr == ALU_ResultM[ADDR_W-1:2]);

  lsu_align #(.DATA_W(DATA_W)) u_align (
    .st_size     (w_size),
    .st_lo       (ALU_ResultM[1:0]),
    .st_data     (WriteDataM),
    .st_be       (w_st_be),
    .st_wdata    (w_st_wdata),
    .ld_size     (r_size),
    .ld_unsigned (r_unsigned),
    .ld_lo       (r_lo),
    .ld_raw      (bus.mem_rdata),
    .ld_data     (w_ld_data)
  );

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: if (w_access) w_state_next = (w_misalign || (isSCM && !w_sc_ok)) ? DONE : REQ;
      REQ:  if (bus.mem_gnt) w_state_next = WAIT;
      WAIT: if (bus.mem_rvalid) w_state_next = DONE;
      DONE: w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_size      <= SZ_W;
      r_unsigned  <= 1'b0;
      r_we        <= 1'b0;
      r_lr        <= 1'b0;
      r_sc        <= 1'b0;
      r_misalign  <= 1'b0;
      r_lo        <= 2'b00;
      r_addr      <= '0;
      r_be        <= 4'b0000;
      r_wdata     <= '0;
      r_rdata     <= '0;
      r_rsv_addr  <= '0;
      r_rsv_valid <= 1'b0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        IDLE: if (w_access) begin
          r_addr     <= {ALU_ResultM[ADDR_W-1:2], 2'b00};
          r_be       <= w_st_be;
          r_wdata    <= w_st_wdata;
          r_we       <= w_we;
          r_size     <= w_size;
          r_unsigned <= funct3M[2];
          r_lo       <= ALU_ResultM[1:0];
          r_lr       <= isLRM;
          r_sc       <= isSCM;
          r_misalign <= w_misalign;
          // A failed SC reports 1 without touching the bus.
          r_rdata    <= (isSCM && !w_misalign && !w_sc_ok) ? DATA_W'(1) : '0;
        end
        WAIT: if (bus.mem_rvalid) r_rdata <= r_we ? '0 : w_ld_data;
        DONE: begin
          if (r_sc) begin
            r_rsv_valid <= 1'b0;
          end else if (!r_misalign) begin
            if (r_lr && RSV_EN) begin
              r_rsv_addr  <= r_addr[ADDR_W-1:2];
              r_rsv_valid <= 1'b1;
            end else if (r_we && (r_addr[ADDR_W-1:2] == r_rsv_addr)) begin
              r_rsv_valid <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Gated with rst so that every output reads 0 while reset is held.
  assign StallM        = rst && w_access && (r_state != DONE);
  assign MisalignM     = (r_state == DONE) && r_misalign;
  assign ReadDataM     = r_rdata;
  assign bus.mem_req   = (r_state == REQ);
  assign bus.mem_we    = r_we;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_be    = r_be;
  assign bus.mem_wdata = r_wdata;

endmodule

// File: tb/tb_memory_stage_lsu.sv
// Directed bench: driver pushes expected results into queues, monitors pop
// and compare on each bus grant and each DONE cycle.
module tb_memory_stage_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        MemReadM = 0, MemWriteM = 0, isFPUM = 0, isLRM = 0, isSCM = 0;
  logic [2:0]  funct3M = 3'b000;
  logic [31:0] ALU_ResultM = '0, WriteDataM = '0;
  logic [31:0] ReadDataM;
  logic        StallM, MisalignM;

  int checks = 0;
  int errors = 0;
  int gnt_dly = 0, rv_dly = 0;
  logic [31:0] mem_rd = '0;

  typedef struct {string nm; logic [31:0] rd; logic chk_rd; logic mis;} done_t;
  typedef struct {string nm; logic we; logic [31:0] addr; logic [3:0] be; logic [31:0] wdata;} bus_t;
  done_t done_q[$];
  bus_t  bus_q[$];

  memory_stage_lsu_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  memory_stage_lsu #(.ADDR_W(32), .DATA_W(32), .RSV_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .MemReadM(MemReadM), .MemWriteM(MemWriteM),
    .isFPUM(isFPUM), .isLRM(isLRM), .isSCM(isSCM), .funct3M(funct3M),
    .ALU_ResultM(ALU_ResultM), .WriteDataM(WriteDataM), .ReadDataM(ReadDataM),
    .StallM(StallM), .MisalignM(MisalignM), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Memory responder: gnt after gnt_dly REQ cycles, rvalid after rv_dly WAIT cycles.
  initial begin
    int phase = 0;
    int cnt = 0;
    bus.mem_gnt = 0; bus.mem_rvalid = 0; bus.mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      bus.mem_gnt = 0; bus.mem_rvalid = 0;
      if (phase == 0) begin
        if (bus.mem_req) begin
          if (cnt == gnt_dly) begin bus.mem_gnt = 1; phase = 1; cnt = 0; end
          else cnt++;
        end
      end else begin
        if (cnt == rv_dly) begin
          bus.mem_rvalid = 1; bus.mem_rdata = mem_rd; phase = 0; cnt = 0;
        end else cnt++;
      end
    end
  end

  // Monitor: compare bus on grant and results on DONE.
  always @(negedge clk) begin
    if (rst) begin
      if (bus.mem_req && bus.mem_gnt) begin
        if (bus_q.size() == 0) chk("unexpected_bus", 32'd1, 32'd0);
        else begin
          bus_t b;
          b = bus_q.pop_front();
          chk({b.nm, "_we"}, {31'd0, bus.mem_we}, {31'd0, b.we});
          chk({b.nm, "_addr"}, bus.mem_addr, b.addr);
          chk({b.nm, "_be"}, {28'd0, bus.mem_be}, {28'd0, b.be});
          chk({b.nm, "_wdata"}, bus.mem_wdata, b.wdata);
          $display("bus  %s we=%0b addr=%h be=%b wdata=%h", b.nm, bus.mem_we, bus.mem_addr, bus.mem_be, bus.mem_wdata);
        end
      end
      if ((MemReadM | MemWriteM | isLRM | isSCM) && !StallM) begin
        if (done_q.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
        else begin
          done_t d;
          d = done_q.pop_front();
          if (d.chk_rd) chk({d.nm, "_rdata"}, ReadDataM, d.rd);
          chk({d.nm, "_misalign"}, {31'd0, MisalignM}, {31'd0, d.mis});
          $display("done %s rdata=%h mis=%0b", d.nm, ReadDataM, MisalignM);
        end
      end
    end
  end

  task automatic clear_inputs();
    MemReadM = 0; MemWriteM = 0; isFPUM = 0; isLRM = 0; isSCM = 0;
    funct3M = 3'b000; ALU_ResultM = '0; WriteDataM = '0;
  endtask

  // kind: 0 load, 1 store, 2 FP load, 3 LR, 4 SC
  task automatic op(input string nm, input int kind, input logic [2:0] f3,
                    input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rdata,
                    input int gd, input int rd_d, input logic has_bus, input logic [3:0] be,
                    input logic [31:0] bus_wdata, input logic chk_rd, input logic [31:0] exp_rd,
                    input logic exp_mis);
    int stalls = 0;
    int reqs = 0;
    bit done = 0;
    bus_t b;
    done_t d;
    @(posedge clk); #1;
    gnt_dly = gd; rv_dly = rd_d; mem_rd = rdata;
    if (has_bus) begin
      b.nm = nm; b.we = (kind == 1 || kind == 4); b.addr = {addr[31:2], 2'b00};
      b.be = be; b.wdata = bus_wdata;
      bus_q.push_back(b);
    end
    d.nm = nm; d.rd = exp_rd; d.chk_rd = chk_rd; d.mis = exp_mis;
    done_q.push_back(d);
    MemReadM = (kind == 0 || kind == 2); MemWriteM = (kind == 1);
    isFPUM = (kind == 2); isLRM = (kind == 3); isSCM = (kind == 4);
    funct3M = f3; ALU_ResultM = addr; WriteDataM = wdata;
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      if (bus.mem_req) reqs++;
      if (StallM) stalls++;
      else begin done = 1; break; end
    end
    if (!done) chk({nm, "_timeout"}, 32'd0, 32'd1);
    chk({nm, "_stall_cycles"}, stalls, has_bus ? 3 + gd + rd_d : 1);
    chk({nm, "_req_cycles"}, reqs, has_bus ? gd + 1 : 0);
    @(posedge clk); #1;
    clear_inputs();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_rdata", ReadDataM, 32'd0);
    chk("rst_stall", {31'd0, StallM}, 32'd0);
    chk("rst_misalign", {31'd0, MisalignM}, 32'd0);
    chk("rst_req", {31'd0, bus.mem_req}, 32'd0);
    chk("rst_addr_be", {bus.mem_addr[27:0], bus.mem_be}, 32'd0);
    chk("rst_wdata", bus.mem_wdata, 32'd0);
    rst = 1;

    //  name        kind f3      addr          wdata          rdata        gd rv bus be       bus_wdata     chk exp_rd       mis
    op("lb",        0, 3'b000, 32'h103, 32'h0,        32'h80FF_FFFF, 0, 0, 1, 4'b1000, 32'h0,         1, 32'hFFFF_FF80, 0);
    op("lbu",       0, 3'b100, 32'h103, 32'h0,        32'h80FF_FFFF, 0, 0, 1, 4'b1000, 32'h0,         1, 32'h0000_0080, 0);
    op("lh",        0, 3'b001, 32'h102, 32'h0,        32'h80FF_1234, 0, 0, 1, 4'b1100, 32'h0,         1, 32'hFFFF_80FF, 0);
    op("lhu",       0, 3'b101, 32'h102, 32'h0,        32'h80FF_1234, 0, 0, 1, 4'b1100, 32'h0,         1, 32'h0000_80FF, 0);
    op("lw",        0, 3'b010, 32'h100, 32'h0,        32'hDEAD_BEEF, 1, 2, 1, 4'b1111, 32'h0,         1, 32'hDEAD_BEEF, 0);
    op("sh",        1, 3'b001, 32'h202, 32'h0000_ABCD, 32'h0,        0, 0, 1, 4'b1100, 32'hABCD_ABCD, 0, 32'h0,         0);
    op("sb",        1, 3'b000, 32'h301, 32'h1234_565A, 32'h0,        0, 0, 1, 4'b0010, 32'h5A5A_5A5A, 0, 32'h0,         0);
    op("sw_slow",   1, 3'b010, 32'h404, 32'h1122_3344, 32'h0,        3, 1, 1, 4'b1111, 32'h1122_3344, 0, 32'h0,         0);
    op("flw",       2, 3'b000, 32'h108, 32'h0,        32'h3F80_0000, 0, 0, 1, 4'b1111, 32'h0,         1, 32'h3F80_0000, 0);
    op("lw_f3_011", 0, 3'b011, 32'h104, 32'h0,        32'h1234_5678, 0, 0, 1, 4'b1111, 32'h0,         1, 32'h1234_5678, 0);
    op("lr",        3, 3'b010, 32'h040, 32'h0,        32'hCAFE_F00D, 0, 0, 1, 4'b1111, 32'h0,         1, 32'hCAFE_F00D, 0);
    op("sc_ok",     4, 3'b010, 32'h040, 32'h0000_0077, 32'h0,        0, 0, 1, 4'b1111, 32'h0000_0077, 1, 32'h0,         0);
    op("sc_again",  4, 3'b010, 32'h040, 32'h0000_0088, 32'h0,        0, 0, 0, 4'b0000, 32'h0,         1, 32'h1,         0);
    op("lw_mis",    0, 3'b010, 32'h102, 32'h0,        32'h0,        0, 0, 0, 4'b0000, 32'h0,         1, 32'h0,         1);
    op("lr2",       3, 3'b010, 32'h080, 32'h0,        32'h0000_0001, 0, 0, 1, 4'b1111, 32'h0,         1, 32'h0000_0001, 0);
    op("sw_rsv",    1, 3'b010, 32'h080, 32'h0000_0005, 32'h0,        0, 0, 1, 4'b1111, 32'h0000_0005, 0, 32'h0,         0);
    op("sc_killed", 4, 3'b010, 32'h080, 32'h0000_0009, 32'h0,        0, 0, 0, 4'b0000, 32'h0,         1, 32'h1,         0);

    // Reset while WAIT is pending; the late rvalid must be ignored.
    begin
      bus_t b;
      bit seen = 0;
      @(posedge clk); #1;
      gnt_dly = 0; rv_dly = 4; mem_rd = 32'h5555_AAAA;
      b.nm = "lw_rst"; b.we = 0; b.addr = 32'h500; b.be = 4'b1111; b.wdata = 32'h0;
      bus_q.push_back(b);
      MemReadM = 1; funct3M = 3'b010; ALU_ResultM = 32'h500;
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        if (bus.mem_req) begin seen = 1; break; end
      end
      chk("lw_rst_req_seen", {31'd0, seen}, 32'd1);
      @(posedge clk); #2;
      rst = 0; #1;
      chk("rst_wait_req", {31'd0, bus.mem_req}, 32'd0);
      chk("rst_wait_stall", {31'd0, StallM}, 32'd0);
      chk("rst_wait_rdata", ReadDataM, 32'd0);
      clear_inputs();
      @(negedge clk); rst = 1;
      repeat (8) @(negedge clk);
      chk("late_rvalid_rdata", ReadDataM, 32'd0);
      chk("late_rvalid_req", {31'd0, bus.mem_req}, 32'd0);
      $display("rst  lw_rst abandoned rdata=%h req=%0b", ReadDataM, bus.mem_req);
    end
    op("lw_after",  0, 3'b010, 32'h100, 32'h0,        32'h0BAD_F00D, 0, 0, 1, 4'b1111, 32'h0,         1, 32'h0BAD_F00D, 0);

    repeat (3) @(negedge clk);
    chk("bus_q_empty", bus_q.size(), 32'd0);
    chk("done_q_empty", done_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
